// File: rtl/fp32_pkg.sv
// ---------------------------------------------------------------------------
// fp32_pkg
// Shared types and constants for the single-precision adder: the IEEE-754
// field layout, the adder state encoding and a mantissa unpack helper that
// flushes denormals to zero.
// ---------------------------------------------------------------------------
package fp32_pkg;

  localparam int          EXP_BIAS = 127;
  localparam logic [7:0]  EXP_MAX  = 8'hFF;
  localparam logic [31:0] POS_INF  = 32'h7F80_0000;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam int          MANT_W   = 24;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_fields_t;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    PACK
  } fp32_state_t;

  // Zero exponent means zero: the fraction is ignored, so denormals flush.
  function automatic logic [MANT_W-1:0] unpack_mant(input fp32_fields_t f);
    if (f.exp == 8'd0) begin
      return '0;
    end
    return {1'b1, f.frac};
  endfunction

endpackage

// File: rtl/fp32_adder_if.sv
// ---------------------------------------------------------------------------
// fp32_adder_if
// Operand/result bundle of the fp32 adder.
//   A, B   : operands, sampled when En is accepted in IDLE
//   En     : start strobe
//   Sum    : registered result, held until the next result or reset
//   Ready  : one-cycle pulse when Sum updates
// master : the requester driving operands; slave : the adder.
// ---------------------------------------------------------------------------
interface fp32_adder_if;

  logic [31:0] A;
  logic [31:0] B;
  logic        En;
  logic [31:0] Sum;
  logic        Ready;

  modport master (output A, output B, output En, input Sum, input Ready);
  modport slave  (input A, input B, input En, output Sum, output Ready);

endinterface

// File: rtl/fp32_align_shift.sv
// ---------------------------------------------------------------------------
// fp32_align_shift
// Combinational alignment shifter for the smaller mantissa.
//   mant_in  : 24-bit mantissa (hidden bit included)
//   shamt    : exponent difference
//   mant_out : mant_in >> shamt, forced to zero once shamt reaches 25
// Shifted-out bits are dropped (truncation, no guard/sticky).
// ---------------------------------------------------------------------------
module fp32_align_shift
  import fp32_pkg::*;
(
  input  logic [MANT_W-1:0] mant_in,
  input  logic [7:0]        shamt,
  output logic [MANT_W-1:0] mant_out
);

  always_comb begin
    mant_out = '0;
    if (shamt < 8'd25) begin
      mant_out = mant_in >> shamt;
    end
  end

endmodule

// File: rtl/fp32_adder.sv
// ---------------------------------------------------------------------------
// fp32_adder
// Multi-cycle IEEE-754 single-precision adder. Operands are captured on En
// in IDLE, then walk ALIGN -> ADD -> NORM (one normalize step per cycle) ->
// PACK. Denormals flush to zero, results truncate, overflow saturates to a
// signed infinity. Latency is 4 + (number of left normalize shifts) edges.
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low reset
//   bus    : fp32_adder_if slave (A, B, En in; Sum, Ready out)
// Build option: FP_ADD_SPECIALS_EN treats exponent-255 inputs as NaN/inf
// (NaN or +inf + -inf gives quiet NaN, otherwise infinity propagates).
// Without it those inputs are ordinary numbers in the datapath.
// ---------------------------------------------------------------------------
module fp32_adder (
  input  logic          clk,
  input  logic          reset,
  fp32_adder_if.slave   bus
);

  import fp32_pkg::*;

  fp32_state_t state;
  fp32_state_t state_nxt;

  logic [31:0]       a_r;
  logic [31:0]       b_r;
  fp32_fields_t      a_f;
  fp32_fields_t      b_f;
  fp32_fields_t      lg_f;
  fp32_fields_t      sm_f;
  logic              swap;
  logic [MANT_W-1:0] mant_lg;
  logic [MANT_W-1:0] mant_sm;
  logic [MANT_W-1:0] mant_sm_shifted;
  logic [7:0]        exp_diff;

  logic [MANT_W-1:0] lg_r;
  logic [MANT_W-1:0] sm_r;
  logic              sub_r;
  logic              sign_r;
  logic signed [9:0] exp_r;
  logic [MANT_W:0]   mant_r;
  logic              norm_done;

  logic              spec_hit;
  logic [31:0]       spec_val;
  logic [31:0]       pack_val;
  logic [31:0]       sum_r;
  logic              ready_r;

  // Pick the larger magnitude by raw {exp, frac}; ties keep A. The larger
  // operand sets the reference exponent and the result sign.
  always_comb begin
    a_f      = a_r;
    b_f      = b_r;
    swap     = (b_r[30:0] > a_r[30:0]);
    lg_f     = swap ? b_f : a_f;
    sm_f     = swap ? a_f : b_f;
    mant_lg  = unpack_mant(lg_f);
    mant_sm  = unpack_mant(sm_f);
    exp_diff = lg_f.exp - sm_f.exp;
  end

  fp32_align_shift u_align (
    .mant_in  (mant_sm),
    .shamt    (exp_diff),
    .mant_out (mant_sm_shifted)
  );

  // Normalization stops on a carry (handled by one right shift), on a set
  // hidden bit, or on an all-zero mantissa.
  assign norm_done = mant_r[MANT_W] | mant_r[MANT_W-1] | (mant_r == '0);

`ifdef FP_ADD_SPECIALS_EN
  // Captured operands stay put for the whole operation, so the special-value
  // result is decoded straight from them and simply selected in PACK.
  logic a_nan, b_nan, a_inf, b_inf;

  always_comb begin
    a_nan    = (a_f.exp == EXP_MAX) && (a_f.frac != 23'd0);
    b_nan    = (b_f.exp == EXP_MAX) && (b_f.frac != 23'd0);
    a_inf    = (a_f.exp == EXP_MAX) && (a_f.frac == 23'd0);
    b_inf    = (b_f.exp == EXP_MAX) && (b_f.frac == 23'd0);
    spec_hit = (a_f.exp == EXP_MAX) || (b_f.exp == EXP_MAX);
    spec_val = QNAN;
    if (a_nan || b_nan || (a_inf && b_inf && (a_f.sign != b_f.sign))) begin
      spec_val = QNAN;
    end else if (a_inf) begin
      spec_val = POS_INF | {a_f.sign, 31'd0};
    end else begin
      spec_val = POS_INF | {b_f.sign, 31'd0};
    end
  end
`else
  assign spec_hit = 1'b0;
  assign spec_val = 32'd0;
`endif

  // Final packing: exact cancellation is always +0, then saturation and
  // underflow, otherwise the normalized fields.
  always_comb begin
    pack_val = {sign_r, exp_r[7:0], mant_r[22:0]};
    if (spec_hit) begin
      pack_val = spec_val;
    end else if (mant_r == '0) begin
      pack_val = 32'd0;
    end else if (exp_r >= $signed({2'b00, EXP_MAX})) begin
      pack_val = POS_INF | {sign_r, 31'd0};
    end else if (exp_r <= 10'sd0) begin
      pack_val = {sign_r, 31'd0};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.En) state_nxt = ALIGN;
      ALIGN:   state_nxt = ADD;
      ADD:     state_nxt = NORM;
      NORM:    if (norm_done || spec_hit) state_nxt = PACK;
      PACK:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers advance with the state; En outside IDLE is ignored
  // because capture only happens in the IDLE branch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_r     <= '0;
      b_r     <= '0;
      lg_r    <= '0;
      sm_r    <= '0;
      sub_r   <= 1'b0;
      sign_r  <= 1'b0;
      exp_r   <= '0;
      mant_r  <= '0;
      sum_r   <= '0;
      ready_r <= 1'b0;
    end else begin
      ready_r <= (state == PACK);
      case (state)
        IDLE: begin
          if (bus.En) begin
            a_r <= bus.A;
            b_r <= bus.B;
          end
        end
        ALIGN: begin
          lg_r   <= mant_lg;
          sm_r   <= mant_sm_shifted;
          sub_r  <= lg_f.sign ^ sm_f.sign;
          sign_r <= lg_f.sign;
          exp_r  <= $signed({2'b00, lg_f.exp});
        end
        ADD: begin
          if (sub_r) begin
            mant_r <= {1'b0, lg_r} - {1'b0, sm_r};
          end else begin
            mant_r <= {1'b0, lg_r} + {1'b0, sm_r};
          end
        end
        NORM: begin
          if (mant_r[MANT_W]) begin
            mant_r <= mant_r >> 1;
            exp_r  <= exp_r + 10'sd1;
          end else if (!norm_done) begin
            mant_r <= mant_r << 1;
            exp_r  <= exp_r - 10'sd1;
          end
        end
        PACK: begin
          sum_r <= pack_val;
        end
        default: ;
      endcase
    end
  end

  assign bus.Sum   = sum_r;
  assign bus.Ready = ready_r;

endmodule

// File: tb/tb_fp32_adder.sv
// ---------------------------------------------------------------------------
// tb_fp32_adder
// Self-checking bench for fp32_adder: directed vectors, random operands
// against an arithmetic reference model, reset abort, busy-En and
// back-to-back starts.
// ---------------------------------------------------------------------------
module tb_fp32_adder;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fp32_adder_if bus ();

  fp32_adder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Reference: integer mantissas, exponent derived from the leading-one
  // position of the raw sum, n = left shifts needed to reach bit 23.
  function automatic void ref_add(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] s, output int n);
    int     ea, eb, el, es, d, pos, e;
    longint ma, mb, ml, ms, r, f;
    logic   sl, ss;
    n  = 0;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
`ifdef FP_ADD_SPECIALS_EN
    if (ea == 255 || eb == 255) begin
      if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0) ||
          (ea == 255 && eb == 255 && a[31] != b[31]))
        s = 32'h7FC0_0000;
      else if (ea == 255)
        s = {a[31], 8'hFF, 23'h0};
      else
        s = {b[31], 8'hFF, 23'h0};
      return;
    end
`endif
    ma = (ea == 0) ? 0 : (longint'(a[22:0]) + 64'h80_0000);
    mb = (eb == 0) ? 0 : (longint'(b[22:0]) + 64'h80_0000);
    if (b[30:0] > a[30:0]) begin
      el = eb; es = ea; ml = mb; ms = ma; sl = b[31]; ss = a[31];
    end else begin
      el = ea; es = eb; ml = ma; ms = mb; sl = a[31]; ss = b[31];
    end
    d  = el - es;
    ms = (d >= 25) ? 0 : (ms >> d);
    r  = (sl == ss) ? (ml + ms) : (ml - ms);
    if (r == 0) begin
      s = 32'h0;
      return;
    end
    pos = 0;
    for (int i = 0; i < 25; i++) if (r[i]) pos = i;
    if (pos < 23) n = 23 - pos;
    e = el + pos - 23;
    f = (pos > 23) ? (r >> 1) : (r << (23 - pos));
    if (e >= 255)    s = {sl, 8'hFF, 23'h0};
    else if (e <= 0) s = {sl, 31'h0};
    else             s = {sl, e[7:0], f[22:0]};
  endfunction

  // One operation: strobe En, scramble operands after capture, time Ready.
  task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] exp_sum, input int exp_n,
                                input string tag);
    int          lat;
    logic [31:0] held;
    @(negedge clk);
    bus.A  = a;
    bus.B  = b;
    bus.En = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.En = 1'b0;
    bus.A  = $urandom;
    bus.B  = $urandom;
    lat = 0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.Ready) begin
        lat = c;
        break;
      end
    end
    check_output({tag, " sum"}, bus.Sum, exp_sum);
    check_output({tag, " latency"}, lat, 4 + exp_n);
    held = bus.Sum;
    @(negedge clk);
    check_output({tag, " ready width"}, {31'd0, bus.Ready}, 32'd0);
    check_output({tag, " sum hold"}, bus.Sum, held);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb, rs, tmp;
    logic [7:0]  bexp;
    int          rn, mode, cnt, lat1, lat2;
    logic [31:0] sum1, sum2;

    bus.A  = 32'd0;
    bus.B  = 32'd0;
    bus.En = 1'b0;
    reset  = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset sum", bus.Sum, 32'd0);
    check_output("reset ready", {31'd0, bus.Ready}, 32'd0);
    reset = 1'b1;

    apply_stimulus(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 0,  "one_plus_two");
    apply_stimulus(32'h3F00_0000, 32'h3F00_0000, 32'h3F80_0000, 0,  "carry");
    apply_stimulus(32'hBFC0_0000, 32'h4020_0000, 32'h3F80_0000, 1,  "mixed_sign");
    apply_stimulus(32'hC120_0000, 32'hC0C0_0000, 32'hC180_0000, 0,  "neg_neg");
    apply_stimulus(32'h40B8_0000, 32'hC0B8_0000, 32'h0000_0000, 0,  "cancel");
    apply_stimulus(32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 0,  "overflow");
    apply_stimulus(32'h7E80_0000, 32'h7F00_0000, 32'h7F40_0000, 0,  "near_max");
    apply_stimulus(32'h3F80_0000, 32'hBF7F_FFFF, 32'h3400_0000, 23, "long_norm");
    apply_stimulus(32'h0000_0000, 32'h41C8_0000, 32'h41C8_0000, 0,  "zero_a");
    apply_stimulus(32'h8000_0000, 32'hBF7F_FFFF, 32'hBF7F_FFFF, 0,  "neg_zero_a");
    apply_stimulus(32'hBF80_0000, 32'h1F00_0000, 32'hBF80_0000, 0,  "tiny_b");
    apply_stimulus(32'h0200_0000, 32'h0100_0000, 32'h0220_0000, 0,  "small_exps");

    // Reset pulled low while normalizing aborts the operation.
    @(negedge clk);
    bus.A  = 32'h3F80_0000;
    bus.B  = 32'hBF7F_FFFF;
    bus.En = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.En = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b0;
    #1;
    check_output("abort sum", bus.Sum, 32'd0);
    check_output("abort ready", {31'd0, bus.Ready}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.Ready) cnt++;
    end
    check_output("abort no ready", cnt, 0);
    check_output("abort sum stays", bus.Sum, 32'd0);
    apply_stimulus(32'hC120_0000, 32'hC0C0_0000, 32'hC180_0000, 0, "after_abort");

    // En pulsed while busy is ignored.
    @(negedge clk);
    bus.A  = 32'h3F80_0000;
    bus.B  = 32'h4000_0000;
    bus.En = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.En = 1'b0;
    @(negedge clk);
    bus.A  = 32'h3F00_0000;
    bus.B  = 32'h3F00_0000;
    bus.En = 1'b1;
    @(negedge clk);
    bus.En = 1'b0;
    lat1 = 0;
    for (int c = 3; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.Ready) begin
        lat1 = c;
        break;
      end
    end
    check_output("busy en sum", bus.Sum, 32'h4040_0000);
    check_output("busy en latency", lat1, 4);
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.Ready) cnt++;
    end
    check_output("busy en no second result", cnt, 0);

    // En held high across the return to IDLE starts the next operation.
    @(negedge clk);
    bus.A  = 32'h3F80_0000;
    bus.B  = 32'h4000_0000;
    bus.En = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.A  = 32'h3F00_0000;
    bus.B  = 32'h3F00_0000;
    lat1 = 0; lat2 = 0; sum1 = '0; sum2 = '0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 5) bus.En = 1'b0;
      if (bus.Ready) begin
        if (lat1 == 0) begin
          lat1 = c; sum1 = bus.Sum;
        end else if (lat2 == 0) begin
          lat2 = c; sum2 = bus.Sum;
        end
      end
    end
    check_output("held en first sum", sum1, 32'h4040_0000);
    check_output("held en first latency", lat1, 4);
    check_output("held en second sum", sum2, 32'h3F80_0000);
    check_output("held en second latency", lat2, 9);

    // Random operands: fully random, nearby exponents, near-cancellation.
    for (int k = 0; k < 200; k++) begin
      mode = $urandom_range(0, 2);
      ra   = $urandom;
      tmp  = $urandom;
      if (mode == 0) begin
        rb = $urandom;
      end else if (mode == 1) begin
        bexp = ra[30:23] + 8'($urandom_range(0, 6)) - 8'd3;
        rb   = {tmp[31], bexp, tmp[22:0]};
      end else begin
        rb = {~ra[31], ra[30:8], tmp[7:0]};
      end
      ref_add(ra, rb, rs, rn);
      apply_stimulus(ra, rb, rs, rn, $sformatf("rand%0d %h+%h", k, ra, rb));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
